// File: rtl/adc_ctrl_pkg.sv
// Package: adc_ctrl_pkg
// Shared definitions for the ADC serial-config sequencer:
//   - control-word field positions
//   - sequencer state encoding (also exported through the optional status word)
//   - status word width
package adc_ctrl_pkg;

    localparam int unsigned CTRL_W     = 32;
    localparam int unsigned TOGGLE_BIT = 31;
    localparam int unsigned STATUS_W   = 32;

    // Explicit encodings: the value is visible to software via status_word[27:24].
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_SHIFT = 4'd2,
        ST_HOLD  = 4'd3,
        ST_GAP   = 4'd4
    } adc_state_e;

endpackage

// File: rtl/adc_ctrl_tick_gen.sv
// Module: adc_ctrl_tick_gen
// Divides user_clk by CLK_DIV and emits a one-cycle tick on the last cycle of
// each period. A synchronous restart clears the divider so that the first
// tick lands exactly CLK_DIV cycles after the restart cycle.
// Ports:
//   user_clk    in   clock
//   user_rst_n  in   asynchronous active-low reset
//   restart     in   synchronous divider restart
//   tick        out  one-cycle pulse every CLK_DIV cycles
module adc_ctrl_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic user_clk,
    input  logic user_rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/adc_ctrl_serial_sequencer.sv
// Module: adc_ctrl_serial_sequencer
// Turns each software request (a toggle of ctrl_word[31]) into one 3-wire
// ADC configuration frame: LOAD, FW bits MSB first (address then data),
// HOLD, then an sldn_n-high GAP before the next frame may start.
// Optional feature macro: ADC_CTRL_STATUS_EN adds the status_word output.
// Ports:
//   user_clk     in   clock (control register domain)
//   user_rst_n   in   asynchronous active-low reset
//   ctrl_word    in   [31] request toggle, [ADDR_W+DATA_W-1:DATA_W] addr, [DATA_W-1:0] data
//   adc_sclk     out  serial clock, idles low
//   adc_sdata    out  serial data, MSB first
//   adc_sldn_n   out  frame enable, active low
//   busy         out  frame in progress (including GAP)
//   done         out  one-cycle pulse at end of GAP
//   frame_cnt    out  completed frames, wrapping
//   status_word  out  (ADC_CTRL_STATUS_EN only) {busy, pending, 2'b0, state, last_addr, frame_cnt}
module adc_ctrl_serial_sequencer
    import adc_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned GAP_HP  = 4
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [CTRL_W-1:0] ctrl_word,
    output logic              adc_sclk,
    output logic              adc_sdata,
    output logic              adc_sldn_n,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
`ifdef ADC_CTRL_STATUS_EN
    ,
    output logic [STATUS_W-1:0] status_word
`endif
);

    localparam int unsigned FW  = ADDR_W + DATA_W;
    localparam int unsigned BCW = $clog2(FW);
    localparam int unsigned GCW = $clog2(GAP_HP + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FW - 1);
    localparam logic [GCW-1:0] LAST_GAP = GCW'(GAP_HP - 1);

    logic          req_tog_q;
    logic [FW-1:0] req_frame_q;
    logic          served;
    adc_state_e    state;
    logic [FW-1:0] shreg;
    logic [BCW-1:0] bit_cnt;
    logic [GCW-1:0] gap_cnt;
    logic [15:0]   frame_cnt_q;
    logic          pending;
    logic          start;
    logic          tick;

    // Reserved control bits carry no function.
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^ctrl_word[TOGGLE_BIT-1:FW];

    assign pending   = (req_tog_q != served);
    assign start     = (state == ST_IDLE) && pending;
    assign frame_cnt = frame_cnt_q;

    adc_ctrl_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .restart    (start),
        .tick       (tick)
    );

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            req_tog_q   <= 1'b0;
            req_frame_q <= '0;
            served      <= 1'b0;
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            frame_cnt_q <= '0;
            adc_sclk    <= 1'b0;
            adc_sdata   <= 1'b0;
            adc_sldn_n  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            req_tog_q   <= ctrl_word[TOGGLE_BIT];
            req_frame_q <= ctrl_word[FW-1:0];
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        served     <= req_tog_q;
                        shreg      <= req_frame_q;
                        adc_sdata  <= req_frame_q[FW-1];
                        adc_sclk   <= 1'b0;
                        adc_sldn_n <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        adc_sclk <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (adc_sclk) begin
                            // Falling edge: present the next bit (zero after the last).
                            adc_sclk  <= 1'b0;
                            shreg     <= {shreg[FW-2:0], 1'b0};
                            adc_sdata <= shreg[FW-2];
                        end else if (bit_cnt == LAST_BIT) begin
                            adc_sdata <= 1'b0;
                            state     <= ST_HOLD;
                        end else begin
                            adc_sclk <= 1'b1;
                            bit_cnt  <= bit_cnt + BCW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        adc_sldn_n <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt == LAST_GAP) begin
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            state       <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GCW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADC_CTRL_STATUS_EN
    logic [7:0] last_addr;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            last_addr   <= '0;
            status_word <= '0;
        end else begin
            if (start) begin
                last_addr <= 8'(req_frame_q[FW-1:DATA_W]);
            end
            status_word <= {busy, pending, 2'b00, state, last_addr, frame_cnt_q};
        end
    end
`endif

endmodule

// File: tb/tb_adc_ctrl_serial_sequencer.sv
// Testbench: tb_adc_ctrl_serial_sequencer
// Directed test of adc_ctrl_serial_sequencer with hand-computed frames.
// u_dut uses default parameters; u_dut2 uses CLK_DIV=2 for the wrap test.
`timescale 1ns/1ps
module tb_adc_ctrl_serial_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ctrl_word, ctrl_word2;
    logic        sclk, sdata, sldn_n, busy, done;
    logic        sclk2, sdata2, sldn_n2, busy2, done2;
    logic [15:0] frame_cnt, frame_cnt2;
`ifdef ADC_CTRL_STATUS_EN
    logic [31:0] status_word, status_word2;
`endif

    always #5 clk = ~clk;

    adc_ctrl_serial_sequencer #(
        .CLK_DIV (4), .ADDR_W (3), .DATA_W (16), .GAP_HP (4)
    ) u_dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .ctrl_word  (ctrl_word),
        .adc_sclk   (sclk),
        .adc_sdata  (sdata),
        .adc_sldn_n (sldn_n),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt)
`ifdef ADC_CTRL_STATUS_EN
        ,
        .status_word (status_word)
`endif
    );

    adc_ctrl_serial_sequencer #(
        .CLK_DIV (2), .ADDR_W (3), .DATA_W (16), .GAP_HP (4)
    ) u_dut2 (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .ctrl_word  (ctrl_word2),
        .adc_sclk   (sclk2),
        .adc_sdata  (sdata2),
        .adc_sldn_n (sldn_n2),
        .busy       (busy2),
        .done       (done2),
        .frame_cnt  (frame_cnt2)
`ifdef ADC_CTRL_STATUS_EN
        ,
        .status_word (status_word2)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Optionally writes ctrl_word, waits for sldn_n to fall (lat = negedges
    // waited), then records sdata on every sclk rise until done. Mid-frame
    // ctrl_word rewrites happen at the given cycle offsets (-1 = none).
    task automatic run_frame(input bit kick, input logic [31:0] word,
                             input int tog_at, input logic [31:0] tog_word,
                             input int tog2_at, input logic [31:0] tog2_word,
                             output int lat, output logic [31:0] bits,
                             output int nbits, output int busy_len, output bit got_done);
        logic prev_sclk;
        int   cyc;
        lat = 0; bits = '0; nbits = 0; busy_len = 0; got_done = 1'b0;
        if (kick) ctrl_word = word;
        do begin
            @(negedge clk);
            lat++;
        end while (sldn_n && lat < 40);
        prev_sclk = sclk;
        cyc = 0;
        while (!done && cyc < 1000) begin
            if (busy) busy_len++;
            if (sclk && !prev_sclk) begin
                bits = {bits[30:0], sdata};
                nbits++;
            end
            prev_sclk = sclk;
`ifdef ADC_CTRL_STATUS_EN
            if (cyc == 50) check("status_busy_bit", {31'd0, status_word[31]}, 32'd1);
`endif
            if (cyc == tog_at)  ctrl_word = tog_word;
            if (cyc == tog2_at) ctrl_word = tog2_word;
            @(negedge clk);
            cyc++;
        end
        got_done = done;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          lat, nbits, busy_len, lows, rises, cyc, r1, r2;
        logic [31:0] bits;
        bit          got_done;
        logic        prev;

        // Reset state
        rst_n = 1'b0; ctrl_word = '0; ctrl_word2 = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk",   {31'd0, sclk},   32'd0);
        check("rst_sdata",  {31'd0, sdata},  32'd0);
        check("rst_sldn_n", {31'd0, sldn_n}, 32'd1);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Test 1: single request, addr 2 data 0xABCD
        run_frame(1'b1, 32'h8002_ABCD, -1, '0, -1, '0, lat, bits, nbits, busy_len, got_done);
        check("t1_latency",  lat, 32'd2);
        check("t1_bits",     bits, 32'h0002_ABCD);
        check("t1_nbits",    nbits, 32'd19);
        check("t1_busy_len", busy_len, 32'd176);
        check("t1_done",     {31'd0, got_done}, 32'd1);
        check("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
`ifdef ADC_CTRL_STATUS_EN
        @(negedge clk);
        check("t6_status_after_done", status_word, 32'h0002_0001);
`endif

        // Test 2: two toggles mid-frame leave nothing pending
        run_frame(1'b1, 32'h0002_ABCD, 20, 32'h8002_ABCD, 25, 32'h0002_ABCD,
                  lat, bits, nbits, busy_len, got_done);
        check("t2_bits", bits, 32'h0002_ABCD);
        check("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!sldn_n || busy) lows++;
        end
        check("t2_no_second_frame", lows, 32'd0);
        check("t2_frame_cnt_hold", {16'd0, frame_cnt}, 32'd2);

        // Test 3: one toggle mid-frame with new addr/data queues a frame
        run_frame(1'b1, 32'h8002_ABCD, 30, 32'h0005_1234, -1, '0,
                  lat, bits, nbits, busy_len, got_done);
        check("t3_first_bits", bits, 32'h0002_ABCD);
        run_frame(1'b0, '0, -1, '0, -1, '0, lat, bits, nbits, busy_len, got_done);
        check("t3_back_to_back_lat", lat, 32'd1);
        check("t3_second_bits", bits, 32'h0005_1234);
        check("t3_frame_cnt", {16'd0, frame_cnt}, 32'd4);

        // Test 4: async reset during bit 7 of SHIFT
        ctrl_word = 32'h8003_00FF;
        lat = 0;
        do begin @(negedge clk); lat++; end while (sldn_n && lat < 40);
        prev = sclk; rises = 0; cyc = 0;
        while (rises < 8 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        check("t4_reached_bit7", rises, 32'd8);
        ctrl_word = 32'h0003_00FF;
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_sclk",   {31'd0, sclk},   32'd0);
        check("t4_rst_sldn_n", {31'd0, sldn_n}, 32'd1);
        check("t4_rst_busy",   {31'd0, busy},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (!sldn_n || busy) lows++;
        end
        check("t4_no_resume", lows, 32'd0);
        check("t4_frame_cnt_cleared", {16'd0, frame_cnt}, 32'd0);
        run_frame(1'b1, 32'h8003_00FF, -1, '0, -1, '0, lat, bits, nbits, busy_len, got_done);
        check("t4_new_latency", lat, 32'd2);
        check("t4_new_bits", bits, 32'h0003_00FF);
        check("t4_new_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // Test 5: CLK_DIV=2 instance, frame counter wrap
        force u_dut2.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u_dut2.frame_cnt_q;
        @(negedge clk);
        check("t5_preload", {16'd0, frame_cnt2}, 32'h0000_FFFF);
        ctrl_word2 = 32'h8001_0001;
        lat = 0;
        do begin @(negedge clk); lat++; end while (sldn_n2 && lat < 40);
        check("t5_latency", lat, 32'd2);
        prev = sclk2; cyc = 0; r1 = -1; r2 = -1; busy_len = 0; bits = '0;
        while (!done2 && cyc < 1000) begin
            if (busy2) busy_len++;
            if (sclk2 && !prev) begin
                bits = {bits[30:0], sdata2};
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            prev = sclk2;
            @(negedge clk);
            cyc++;
        end
        check("t5_done", {31'd0, done2}, 32'd1);
        check("t5_sclk_period", r2 - r1, 32'd4);
        check("t5_busy_len", busy_len, 32'd88);
        check("t5_bits", bits, 32'h0001_0001);
        check("t5_wrap", {16'd0, frame_cnt2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
